// File: rtl/btb_ctrl.sv
// BTB control stage: valid/tag/counter arrays per set, fetch lookup with
// same-cycle write bypass, 2-entry resolve queue drained one entry per cycle,
// and a RUN/FLUSH sequencer that invalidates one set per cycle.
module btb_ctrl #(
  parameter int S_INDEX = 4,
  parameter int S_PC    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_PC-1:0]    fetch_pc,
  output logic               pred_hit,
  output logic               pred_taken,
  output logic [S_PC-1:0]    pred_target,
  input  logic               resolve_valid,
  input  logic [S_PC-1:0]    resolve_pc,
  input  logic [S_PC-1:0]    resolve_target,
  input  logic               resolve_taken,
  output logic               resolve_ready,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               da_load,
  output logic [S_INDEX-1:0] da_rindex,
  output logic [S_INDEX-1:0] da_windex,
  output logic [S_PC-1:0]    da_datain,
  input  logic [S_PC-1:0]    da_dataout
);
  localparam int NUM_SETS = 2**S_INDEX;
  localparam int S_TAG    = S_PC - S_INDEX - 2;
  localparam logic [S_INDEX-1:0] LAST_SET = S_INDEX'(NUM_SETS - 1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Queue entry; pc[1:0] never matters so it is not stored.
  typedef struct packed {
    logic [S_PC-3:0] pc;
    logic [S_PC-1:0] target;
    logic            taken;
  } upd_t;

  logic [NUM_SETS-1:0]            valid;
  logic [NUM_SETS-1:0][S_TAG-1:0] tags;
  logic [NUM_SETS-1:0][1:0]       ctr;
  upd_t [1:0]                     q;
  logic                           head, tail;
  logic [1:0]                     count;
  logic [0:0]                     state;
  logic [S_INDEX-1:0]             fcnt;

  logic               run, drain, d_hit, wr_en, push, bypass;
  logic               l_valid;
  logic [S_TAG-1:0]   l_tag;
  logic [1:0]         l_ctr, cur_ctr, wr_ctr;
  upd_t               hd;
  logic [S_INDEX-1:0] d_idx, f_idx;
  logic [S_TAG-1:0]   d_tag, f_tag;
  logic               unused_lsb;

  assign unused_lsb = ^{fetch_pc[1:0], resolve_pc[1:0]};

  assign run     = (state == RUN);
  assign drain   = run && (count != 2'd0);
  assign hd      = q[head];
  assign d_idx   = hd.pc[S_INDEX-1:0];
  assign d_tag   = hd.pc[S_PC-3:S_INDEX];
  assign d_hit   = valid[d_idx] && (tags[d_idx] == d_tag);
  assign wr_en   = drain && (hd.taken || d_hit);
  assign cur_ctr = ctr[d_idx];

  // Counter value written by the drain: saturating step, or weakly-taken on allocate.
  always_comb begin
    wr_ctr = cur_ctr;
    if (hd.taken)
      wr_ctr = d_hit ? ((cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01) : 2'b10;
    else
      wr_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01;
  end

  assign f_idx   = fetch_pc[S_INDEX+1:2];
  assign f_tag   = fetch_pc[S_PC-1:S_INDEX+2];
  // Lookup sees the drain's post-write view of its set, like the data array does.
  assign bypass  = wr_en && (d_idx == f_idx);
  assign l_valid = bypass ? 1'b1   : valid[f_idx];
  assign l_tag   = bypass ? d_tag  : tags[f_idx];
  assign l_ctr   = bypass ? wr_ctr : ctr[f_idx];

  assign pred_hit    = run && l_valid && (l_tag == f_tag);
  assign pred_taken  = pred_hit && l_ctr[1];
  assign pred_target = da_dataout;

  assign resolve_ready = run && (count < 2'd2);
  // A coinciding flush discards the queue, so the push is refused.
  assign push          = resolve_valid && resolve_ready && !flush_req;
  assign flush_busy    = (state == FLUSH);

  assign da_load   = drain && hd.taken;
  assign da_rindex = f_idx;
  assign da_windex = d_idx;
  assign da_datain = hd.target;

  // Valid/counter arrays, queue pointers and the flush sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NUM_SETS; i++) ctr[i] <= 2'b01;
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      state <= RUN;
      fcnt  <= '0;
    end else if (run) begin
      if (wr_en) begin
        valid[d_idx] <= 1'b1;
        ctr[d_idx]   <= wr_ctr;
      end
      if (flush_req) begin
        state <= FLUSH;
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
        fcnt  <= '0;
      end else begin
        count <= count + 2'(push) - 2'(drain);
        if (push)  tail <= ~tail;
        if (drain) head <= ~head;
      end
    end else begin
      valid[fcnt] <= 1'b0;
      ctr[fcnt]   <= 2'b01;
      fcnt        <= fcnt + 1'b1;
      if (fcnt == LAST_SET) state <= RUN;
    end
  end

  // Tags and queue payload carry no reset; valid bits and count guard them.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: resolve_pc[S_PC-1:2], target: resolve_target, taken: resolve_taken};
    if (wr_en) tags[d_idx] <= d_tag;
  end
endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: ordered model of the BTB plus a behavioural data array.
// Array writes are predicted into a queue and checked by a separate monitor.
module tb_btb_ctrl;
  localparam int SI = 4;
  localparam int SP = 32;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SP-1:0] fetch_pc = '0;
  logic          pred_hit, pred_taken;
  logic [SP-1:0] pred_target;
  logic          resolve_valid = 1'b0;
  logic [SP-1:0] resolve_pc = '0, resolve_target = '0;
  logic          resolve_taken = 1'b0;
  logic          resolve_ready;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          da_load;
  logic [SI-1:0] da_rindex, da_windex;
  logic [SP-1:0] da_datain, da_dataout;

  btb_ctrl #(.S_INDEX(SI), .S_PC(SP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_target(resolve_target), .resolve_taken(resolve_taken),
    .resolve_ready(resolve_ready), .flush_req(flush_req), .flush_busy(flush_busy),
    .da_load(da_load), .da_rindex(da_rindex), .da_windex(da_windex),
    .da_datain(da_datain), .da_dataout(da_dataout)
  );

  always #5 clk = ~clk;

  // Target data array with write-through bypass.
  logic [SP-1:0] mem [NS];
  always @(posedge clk) if (da_load) mem[da_windex] <= da_datain;
  assign da_dataout = (da_load && da_windex == da_rindex) ? da_datain : mem[da_rindex];

  typedef struct packed { logic [31:0] pc; logic [31:0] tgt; logic tk; } res_t;
  typedef struct packed { logic [3:0] widx; logic [31:0] data; } wr_t;

  int tests = 0, fails = 0;

  // Reference BTB state.
  bit          mvalid [NS];
  logic [25:0] mtag   [NS];
  int          mctr   [NS];
  logic [31:0] mdata  [NS];
  res_t        mq [$];
  wr_t         expq [$];
  bit          mrun;
  int          mfcnt;
  logic [25:0] tpool [3];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin mvalid[i] = 0; mctr[i] = 1; end
    mq.delete(); expq.delete();
    mrun = 1; mfcnt = 0;
  endtask

  // One clock cycle: drive, predict, sample at negedge, advance the model.
  task automatic step(bit rv, logic [31:0] rpc, logic [31:0] rtgt, bit rtk, bit fl, logic [31:0] fpc);
    bit run, rdy, hit, ehit, etk;
    res_t e;
    int s, fi;
    logic [25:0] t;
    resolve_valid = rv; resolve_pc = rpc; resolve_target = rtgt;
    resolve_taken = rtk; flush_req = fl; fetch_pc = fpc;
    run = mrun;
    rdy = run && mq.size() < 2;
    if (run && mq.size() > 0) begin
      e = mq.pop_front();
      s = int'(e.pc[5:2]); t = e.pc[31:6];
      hit = mvalid[s] && mtag[s] == t;
      if (e.tk) begin
        if (hit) mctr[s] = (mctr[s] == 3) ? 3 : mctr[s] + 1;
        else begin mvalid[s] = 1; mtag[s] = t; mctr[s] = 2; end
        mdata[s] = e.tgt;
        expq.push_back('{widx: e.pc[5:2], data: e.tgt});
      end else if (hit) mctr[s] = (mctr[s] == 0) ? 0 : mctr[s] - 1;
    end
    fi = int'(fpc[5:2]);
    ehit = run && mvalid[fi] && mtag[fi] == fpc[31:6];
    etk  = ehit && mctr[fi] >= 2;
    @(negedge clk);
    chk("pred_hit", {31'b0, pred_hit}, {31'b0, ehit});
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, etk});
    if (ehit) chk("pred_target", pred_target, mdata[fi]);
    chk("resolve_ready", {31'b0, resolve_ready}, {31'b0, rdy});
    chk("flush_busy", {31'b0, flush_busy}, {31'b0, !run});
    if (run) begin
      if (fl) begin mq.delete(); mrun = 0; mfcnt = 0; end
      else if (rv && rdy) mq.push_back('{pc: rpc, tgt: rtgt, tk: rtk});
    end else begin
      mvalid[mfcnt] = 0; mctr[mfcnt] = 1; mfcnt++;
      if (mfcnt == NS) mrun = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(logic [31:0] fpc);
    step(0, 32'h0, 32'h0, 0, 0, fpc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; resolve_valid = 0; flush_req = 0; fetch_pc = 32'h40;
    model_reset();
    #3;
    chk("rst_pred_hit", {31'b0, pred_hit}, 32'h0);
    chk("rst_resolve_ready", {31'b0, resolve_ready}, 32'h1);
    chk("rst_da_load", {31'b0, da_load}, 32'h0);
    chk("rst_flush_busy", {31'b0, flush_busy}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [25:0] tg;
    logic [3:0]  ix;
    logic [1:0]  lo;
    tg = tpool[$urandom_range(0, 2)];
    ix = 4'($urandom);
    lo = 2'($urandom);
    return {tg, ix, lo};
  endfunction

  // Monitor: every array write must match the next predicted write.
  always @(negedge clk) begin : mon
    wr_t w;
    if (rst_n === 1'b1) begin
      if (da_load === 1'b1) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL da_load: got 1 expected 0 at %0t", $time);
        end else begin
          w = expq.pop_front();
          chk("da_windex", {28'b0, da_windex}, {28'b0, w.widx});
          chk("da_datain", da_datain, w.data);
        end
      end else if (expq.size() > 0) begin
        w = expq.pop_front();
        tests++; fails++;
        $display("FAIL da_load: got 0 expected 1 (windex %h) at %0t", w.widx, $time);
      end
    end
  end

  initial begin
    tpool[0] = 26'h0000001; tpool[1] = 26'h0000011; tpool[2] = 26'h2abcde5;
    for (int i = 0; i < NS; i++) mem[i] = '0;
    do_reset();
    idle(32'h40);

    // Allocate, then bypass hit on the drain cycle.
    step(1, 32'h40, 32'h100, 1, 0, 32'h40);
    idle(32'h40);
    idle(32'h40);

    // Three not-taken updates: counter decays, entry stays.
    for (int i = 0; i < 3; i++) step(1, 32'h40, 32'h0, 0, 0, 32'h40);
    idle(32'h40);
    idle(32'h40);

    // Alias on set 0 with a different tag.
    step(1, 32'h440, 32'h200, 1, 0, 32'h40);
    idle(32'h440);
    idle(32'h40);
    idle(32'h440);

    // Back-to-back resolves.
    for (int i = 0; i < 4; i++)
      step(1, 32'h1000 | ((i + 4) << 2), 32'h3000 + i * 4, 1, 0, 32'h1000 | ((i + 4) << 2));
    for (int i = 0; i < 4; i++) idle(32'h1000 | ((i + 4) << 2));

    // Fill sets 0-3, queue more, flush coinciding with a push.
    for (int i = 0; i < 4; i++) step(1, 32'h2000 | (i << 2), 32'h5000 + i, 1, 0, 32'h2000);
    step(1, 32'h2014, 32'h6000, 1, 0, 32'h2000);
    step(1, 32'h2018, 32'h6004, 1, 1, 32'h2000);
    for (int i = 0; i < 18; i++) step(1, 32'h2018, 32'h6008, 1, 0, 32'h2000 | ((i % 8) << 2));
    for (int i = 0; i < 8; i++) idle(32'h2000 | (i << 2));

    // Reset in the middle of a flush.
    step(1, 32'h80, 32'h700, 1, 0, 32'h80);
    step(0, 32'h0, 32'h0, 0, 1, 32'h80);
    for (int i = 0; i < 5; i++) idle(32'h80);
    do_reset();
    idle(32'h80);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 6, rand_pc(), $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 199) == 0, rand_pc());
    for (int i = 0; i < 20; i++) idle(rand_pc());

    chk("expq_drained", expq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
